// File: rtl/mac_seq_unit_if.sv
// Execute-stage MAC operand/result bundle shared by the issuing datapath and mac_seq_unit.
interface mac_seq_unit_if #(
  parameter int unsigned XLEN = 64
);

  // Request side: instruction presence, pipeline control and operands
  logic            MacValidE;
  logic            MacClearE;
  logic            StallE;
  logic            FlushE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;

  // Response side: hazard stall request, completion strobe, accumulator value
  logic            MacBusyE;
  logic            MacDoneE;
  logic [XLEN-1:0] MacResultE;

  // Datapath / hazard unit view
  modport master (
    output MacValidE,
    output MacClearE,
    output StallE,
    output FlushE,
    output SrcAE,
    output SrcBE,
    input  MacBusyE,
    input  MacDoneE,
    input  MacResultE
  );

  // MAC engine view
  modport slave (
    input  MacValidE,
    input  MacClearE,
    input  StallE,
    input  FlushE,
    input  SrcAE,
    input  SrcBE,
    output MacBusyE,
    output MacDoneE,
    output MacResultE
  );

endinterface

// File: rtl/mac_seq_unit.sv
// Multi-cycle multiply-accumulate engine for the Execute stage.
// Sequence: IDLE (capture) -> MUL (product) -> ACC (commit) -> DONE (result held).
// The accumulator persists across MAC instructions; only it is visible outside.
module mac_seq_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic         clk,
  input  logic         reset,
  mac_seq_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_op_a;
  logic [XLEN-1:0] r_op_b;
  logic [XLEN-1:0] r_prod;
  logic [XLEN-1:0] r_acc;
  logic            r_clr;
  logic            r_done;

  logic            w_start;
  logic [XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_acc_base;
  logic [XLEN-1:0] w_acc_next;
  logic            w_busy;

  // A MAC is accepted only from IDLE and only when not being flushed
  assign w_start = bus.MacValidE & ~bus.FlushE;

  // Truncated product: low XLEN bits are identical for signed and unsigned operands
  assign w_prod = r_op_a * r_op_b;

  // Clear-MAC discards the old accumulator; the sum wraps modulo 2^XLEN
  assign w_acc_base = r_clr ? '0 : r_acc;
  assign w_acc_next = w_acc_base + r_prod;

  // Stall request: pending start in IDLE, always while computing, released in DONE
  always_comb begin
    w_busy = 1'b0;
    unique case (r_state)
      S_IDLE: w_busy = w_start;
      S_MUL:  w_busy = 1'b1;
      S_ACC:  w_busy = 1'b1;
      S_DONE: w_busy = 1'b0;
    endcase
  end

  // Sequencer, operand capture, product and accumulator registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_prod  <= '0;
      r_acc   <= '0;
      r_clr   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_op_a  <= bus.SrcAE;
            r_op_b  <= bus.SrcBE;
            r_clr   <= bus.MacClearE;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          if (bus.FlushE) begin
            r_state <= S_IDLE;
          end else begin
            r_prod  <= w_prod;
            r_state <= S_ACC;
          end
        end
        S_ACC: begin
          // A flush here aborts the commit so the accumulator keeps its old value
          if (bus.FlushE) begin
            r_state <= S_IDLE;
          end else begin
            r_acc   <= w_acc_next;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // Hold the result while E is stalled; leave when the instruction moves on
          if (bus.FlushE || !bus.StallE) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.MacBusyE   = w_busy;
  assign bus.MacDoneE   = r_done;
  assign bus.MacResultE = r_acc;

endmodule
